// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the multi-port single-port SRAM.
// The default-width request/response bundles live here.
package sp_ram_pkg;

    localparam int SP_ADDR_WIDTH = 8;
    localparam int SP_DATA_WIDTH = 32;
    localparam int BE_WIDTH      = SP_DATA_WIDTH / 8;

    typedef struct packed {
        logic [SP_ADDR_WIDTH-1:0] addr;
        logic                     we;
        logic [BE_WIDTH-1:0]      be;
        logic [SP_DATA_WIDTH-1:0] wdata;
    } sp_ram_req_t;

    typedef struct packed {
        logic                     rvalid;
        logic [SP_DATA_WIDTH-1:0] rdata;
        logic                     err;
    } sp_ram_rsp_t;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sp_ram_arb_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus granted index.
// Search starts at the rotating pointer; pointer moves past each winner.
module rr_arbiter
    import sp_ram_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int IW        = idx_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IW-1:0]        idx_o,
    output logic                 valid_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   cand;

    // Pick the first requester at or after the pointer, wrapping around
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (IW+1)'(ptr_q) + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_PORTS)) begin
                cand = cand - (IW+1)'(NUM_PORTS);
            end
            if (!valid_o && req_i[cand[IW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IW-1:0];
            end
        end
        if (rst) begin
            valid_o = 1'b0;
        end
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    // Next pointer is one past the winner; unchanged when idle
    always_comb begin
        ptr_d = ptr_q;
        if (valid_o) begin
            if (idx_o == IW'(NUM_PORTS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_o + IW'(1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sp_ram_arb_mp.sv
// Byte-enabled single-port SRAM shared by NUM_PORTS round-robin requestors.
// Optional macro SP_RAM_OUT_REG_EN adds an output register (latency 2).
module sp_ram_arb_mp
    import sp_ram_pkg::*;
#(
    parameter  int NUM_PORTS  = 2,
    parameter  int ADDR_WIDTH = SP_ADDR_WIDTH,
    parameter  int DATA_WIDTH = SP_DATA_WIDTH,
    parameter  int NUM_WORDS  = 2 ** ADDR_WIDTH,
    localparam int BW         = be_width(DATA_WIDTH),
    localparam int IW         = idx_width(NUM_PORTS),
    localparam int MW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 req_i,
    output logic [NUM_PORTS-1:0]                 gnt_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]                 we_i,
    input  logic [NUM_PORTS-1:0][BW-1:0]         be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]                 rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_PORTS-1:0]                 err_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BW-1:0]         be;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic                  rvalid;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    logic [IW-1:0]         gidx;
    logic                  gvalid;
    req_t                  sel;
    logic                  in_range;
    logic [MW-1:0]         widx;
    logic [DATA_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    rsp_t [NUM_PORTS-1:0]  rsp1_q;
    rsp_t [NUM_PORTS-1:0]  rsp_out;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .idx_o   (gidx),
        .valid_o (gvalid)
    );

    // Route the granted port's request to the memory
    always_comb begin
        sel.addr  = addr_i[gidx];
        sel.we    = we_i[gidx];
        sel.be    = be_i[gidx];
        sel.wdata = wdata_i[gidx];
        in_range  = 32'(sel.addr) < 32'(NUM_WORDS);
        widx      = sel.addr[MW-1:0];
        rd        = mem_q[widx];
    end

    // Byte-lane writes; out-of-range addresses never touch the array
    always_ff @(posedge clk) begin
        if (gvalid && sel.we && in_range) begin
            for (int b = 0; b < BW; b++) begin
                if (sel.be[b]) begin
                    mem_q[widx][b*8 +: 8] <= sel.wdata[b*8 +: 8];
                end
            end
        end
    end

    // First response stage: read-first data captured on the grant edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp1_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rsp1_q[p].rvalid <= 1'b0;
            end
            if (gvalid) begin
                rsp1_q[gidx].rvalid <= 1'b1;
                rsp1_q[gidx].err    <= !in_range;
                if (sel.we || !in_range) begin
                    rsp1_q[gidx].rdata <= '0;
                end else begin
                    rsp1_q[gidx].rdata <= rd;
                end
            end
        end
    end

`ifdef SP_RAM_OUT_REG_EN
    rsp_t [NUM_PORTS-1:0] rsp2_q;

    // Extra output register delays every response by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp2_q <= '0;
        end else begin
            rsp2_q <= rsp1_q;
        end
    end

    assign rsp_out = rsp2_q;
`else
    assign rsp_out = rsp1_q;
`endif

    // Unpack response bundles onto the output ports
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid_o[p] = rsp_out[p].rvalid;
            rdata_o[p]  = rsp_out[p].rdata;
            err_o[p]    = rsp_out[p].err;
        end
    end

endmodule
